// File: rtl/axis_crc_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_crc_arb_pkg
//  Description : Shared types and helpers for the CRC32/MPEG-2 engine
//                arbiter. Holds the FSM state encoding, the source-index
//                width helper and a round-robin pick function.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_crc_arb_pkg;

    // Largest supported number of requesters. Request vectors are padded to
    // this width before being handed to rr_pick.
    localparam int unsigned MAX_SRC         = 16;
    localparam int unsigned RR_IDX_W        = 4;
    localparam int unsigned NUM_SRC_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_CRC = 2'd2,
        ST_RESULT   = 2'd3
    } arb_state_t;

    // Width of a source index; never below 1 so a single-bit field exists
    // even for degenerate source counts.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = (n <= 2) ? 1 : $clog2(n);
        return w;
    endfunction

    localparam int unsigned SRC_IDX_W = idx_width(NUM_SRC_DEFAULT);

    // First set bit of req at or above ptr, wrapping at n. Returns ptr when
    // nothing is requesting; callers qualify with their own found flag.
    function automatic int unsigned rr_pick(
        input logic [MAX_SRC-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        int unsigned pick;
        int unsigned idx;
        logic        hit;
        pick = ptr;
        hit  = 1'b0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            idx = (ptr + k) % n;
            if (!hit && (k < n) && req[idx[RR_IDX_W-1:0]]) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage : axis_crc_arb_pkg
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Purely combinational round-robin selector. Given a request
//                vector and a priority pointer it returns the index of the
//                first requester at or above the pointer (with wrap) and a
//                flag saying whether any requester exists.
//  Ports       : i_req   - request vector, one bit per source
//                i_ptr   - index holding highest priority this decision
//                o_grant - selected index (valid when o_found)
//                o_found - at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter
    import axis_crc_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned C_IDX_W = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [C_IDX_W-1:0] i_ptr,
    output logic [C_IDX_W-1:0] o_grant,
    output logic               o_found
);

    logic [MAX_SRC-1:0] w_req_pad;

    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_SRC-1:0] = i_req;
        o_grant                = C_IDX_W'(rr_pick(w_req_pad, 32'(i_ptr), NUM_SRC));
        o_found                = |i_req;
    end

endmodule : axis_rr_arbiter
`default_nettype wire

// File: rtl/axis_crc32_mpeg2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axis_crc32_mpeg2_arbiter
//  Description : Shares one CRC32/MPEG-2 engine between NUM_SRC AXI-Stream
//                packet sources. Round-robin arbitration, locked for a whole
//                packet; the engine's CRC is returned tagged with the source
//                index (tid) and the packet word count (tuser).
//  Ports       : aclk / areset          - clock, synchronous active-high reset
//                s_axis_*               - NUM_SRC packed slave streams
//                eng_t*                 - data stream to the CRC engine
//                eng_crc_t*             - CRC result stream from the engine
//                m_axis_*               - tagged result stream
//                busy                   - FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_crc32_mpeg2_arbiter
    import axis_crc_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned CRC_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]                s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                s_axis_tlast,
    output logic [NUM_SRC-1:0]                s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0]         eng_tdata,
    output logic                              eng_tvalid,
    output logic                              eng_tlast,
    input  logic                              eng_tready,
    input  logic [CRC_WIDTH-1:0]              eng_crc_tdata,
    input  logic                              eng_crc_tvalid,
    output logic                              eng_crc_tready,
    output logic [CRC_WIDTH-1:0]              m_axis_tdata,
    output logic [$clog2(NUM_SRC)-1:0]        m_axis_tid,
    output logic [LEN_WIDTH-1:0]              m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              busy
);

    localparam int unsigned C_IDX_W = idx_width(NUM_SRC);

    arb_state_t                r_state;
    arb_state_t                w_next_state;

    logic [C_IDX_W-1:0]        r_rr_ptr;
    logic [C_IDX_W-1:0]        r_grant;
    logic [LEN_WIDTH-1:0]      r_count;

    logic [CRC_WIDTH-1:0]      r_m_tdata;
    logic [C_IDX_W-1:0]        r_m_tid;
    logic [LEN_WIDTH-1:0]      r_m_tuser;
    logic                      r_m_tvalid;

    logic [C_IDX_W-1:0]        w_arb_grant;
    logic                      w_arb_found;

    logic [AXI_DATA_WIDTH-1:0] w_src_data;
    logic                      w_src_valid;
    logic                      w_src_last;
    logic                      w_eng_hs;

    // ------------------------------------------------------------------
    // Arbitration decision, only consumed while idle
    // ------------------------------------------------------------------
    axis_rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_arbiter (
        .i_req   (s_axis_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_found (w_arb_found)
    );

    // Granted-source mux; r_grant is stable for the whole packet
    assign w_src_data  = s_axis_tdata[r_grant*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_src_valid = s_axis_tvalid[r_grant];
    assign w_src_last  = s_axis_tlast[r_grant];
    assign w_eng_hs    = (r_state == ST_STREAM) && w_src_valid && eng_tready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_eng_hs && w_src_last) begin
                    w_next_state = ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                if (eng_crc_tvalid) begin
                    w_next_state = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (m_axis_tready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The engine path is a pure wire-through from the granted
    // source so that no extra latency is added per word.
    // ------------------------------------------------------------------
    always_comb begin
        s_axis_tready  = '0;
        eng_tdata      = '0;
        eng_tvalid     = 1'b0;
        eng_tlast      = 1'b0;
        eng_crc_tready = 1'b0;
        busy           = (r_state != ST_IDLE);
        case (r_state)
            ST_STREAM: begin
                s_axis_tready[r_grant] = eng_tready;
                eng_tdata              = w_src_data;
                eng_tvalid             = w_src_valid;
                eng_tlast              = w_src_last;
            end
            ST_WAIT_CRC: begin
                eng_crc_tready = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: grant, word count, result and rr pointer
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_count    <= '0;
            r_m_tdata  <= '0;
            r_m_tid    <= '0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    if (w_arb_found) begin
                        r_grant <= w_arb_grant;
                    end
                end
                ST_STREAM: begin
                    // Saturate rather than wrap so an oversized packet
                    // reports the maximum instead of a small bogus length.
                    if (w_eng_hs && (r_count != '1)) begin
                        r_count <= r_count + LEN_WIDTH'(1);
                    end
                end
                ST_WAIT_CRC: begin
                    if (eng_crc_tvalid) begin
                        r_m_tdata  <= eng_crc_tdata;
                        r_m_tid    <= r_grant;
                        r_m_tuser  <= r_count;
                        r_m_tvalid <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (m_axis_tready) begin
                        r_m_tvalid <= 1'b0;
                        // Source that just finished gets lowest priority next.
                        r_rr_ptr   <= (r_grant == C_IDX_W'(NUM_SRC - 1))
                                      ? '0 : (r_grant + C_IDX_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tid    = r_m_tid;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tvalid = r_m_tvalid;

endmodule : axis_crc32_mpeg2_arbiter
`default_nettype wire
